// File: rtl/median_window_3x3.sv
// median_window_3x3: streaming 3x3 neighbourhood generator with two line buffers and end-of-frame self-flush
// Ports: clk, reset (sync, active-high); in_valid/pix_in/in_ready raster pixel input;
//        win_valid/win_out 9-pixel window (slice row*3+col, slice 8 newest); frame_done pulse on last window.
// Optional: define MEDIAN_WINDOW_BORDER_EN to add win_border (window is not a true 3x3 neighbourhood).
module median_window_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   pix_in,
  output logic                in_ready,
  output logic                win_valid,
  output logic [9*DATA_W-1:0] win_out,
  output logic                frame_done
`ifdef MEDIAN_WINDOW_BORDER_EN
  ,
  output logic                win_border
`endif
);
  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(N + 1);
  localparam int FW = $clog2(2 * IMG_W + 2);
  localparam int PW = $clog2(IMG_W);
  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;
  state_t state, state_nx;
  logic run, acc, shift, flushing, last_flush;
  logic [CW-1:0] in_cnt;
  logic [FW-1:0] flush_cnt;
  logic [PW-1:0] ptr;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] w [9];
  logic [DATA_W-1:0] din, lb1_q, lb2_q;
  // run holds in_ready low for the first cycle after reset releases
  always_comb begin
    flushing   = state == FLUSH;
    in_ready   = run && !flushing;
    acc        = in_valid && in_ready;
    shift      = acc || flushing;
    din        = flushing ? '0 : pix_in;
    lb1_q      = lb1[ptr];
    lb2_q      = lb2[ptr];
    last_flush = flushing && flush_cnt == FW'(2 * IMG_W + 1);
    state_nx   = (state == FILL && acc && in_cnt == CW'(2 * IMG_W + 1)) ? STREAM :
                 (state == STREAM && acc && in_cnt == CW'(N - 1)) ? FLUSH :
                 last_flush ? FILL : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      run        <= 1'b0;
      in_cnt     <= '0;
      flush_cnt  <= '0;
      ptr        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) w[i] <= '0;
    end else begin
      state      <= state_nx;
      run        <= 1'b1;
      win_valid  <= (acc && state == STREAM) || flushing;
      frame_done <= last_flush;
      flush_cnt  <= last_flush ? '0 : flush_cnt + FW'(flushing);
      if (acc) in_cnt <= (state_nx == FLUSH) ? '0 : in_cnt + 1'b1;
      // ptr doubles as the column of the incoming pixel; realigned at each frame start
      if (shift) begin
        ptr <= (last_flush || ptr == PW'(IMG_W - 1)) ? '0 : ptr + 1'b1;
        for (int r = 0; r < 3; r++) begin
          w[r*3]   <= w[r*3+1];
          w[r*3+1] <= w[r*3+2];
        end
        w[2] <= lb2_q;
        w[5] <= lb1_q;
        w[8] <= din;
      end
    end
  end
  // line buffers are plain RAM: never reset, overwritten during FILL
  always_ff @(posedge clk) begin
    if (shift) begin
      lb1[ptr] <= din;
      lb2[ptr] <= lb1_q;
    end
  end
  for (genvar i = 0; i < 9; i++) begin : g_out
    assign win_out[i*DATA_W +: DATA_W] = w[i];
  end
`ifdef MEDIAN_WINDOW_BORDER_EN
  always_ff @(posedge clk) begin
    if (reset) win_border <= 1'b0;
    else win_border <= shift && (flushing || ptr < PW'(2));
  end
`endif
endmodule

// File: tb/tb_median_window_3x3.sv
// tb_median_window_3x3: randomized self-checking bench for median_window_3x3 against a raster-index window model
module tb_median_window_3x3;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int DW = 8;
  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic [DW-1:0] pix_in = '0;
  logic in_ready, win_valid, frame_done;
  logic [9*DW-1:0] win_out;
`ifdef MEDIAN_WINDOW_BORDER_EN
  logic win_border;
`endif
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] frame [N];

  always #5 clk = ~clk;

  median_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pix_in(pix_in),
    .in_ready(in_ready), .win_valid(win_valid), .win_out(win_out), .frame_done(frame_done)
`ifdef MEDIAN_WINDOW_BORDER_EN
    , .win_border(win_border)
`endif
  );

  // window whose newest pixel has raster index p; indices past the frame are flush zeros
  function automatic logic [9*DW-1:0] exp_win(input int p);
    logic [9*DW-1:0] e;
    e = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int q;
        q = p - (2 - r) * W - (2 - c);
        e[(r*3+c)*DW +: DW] = (q < N) ? frame[q] : '0;
      end
    return e;
  endfunction

  task automatic test_reset();
    reset = 1;
    in_valid = 1;
    pix_in = 8'($urandom);
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
    checks++; if (win_out !== '0) begin errors++; $display("FAIL reset_win_out got=%h exp=0", win_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    reset = 0;
    in_valid = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", in_ready); end
  endtask

  // mode 0: continuous, index pattern; 1: alternating bubbles; 2: random valid + 0xFF driven in flush; 3: continuous random
  task automatic run_frame(input int mode);
    int acc_n = 0, win_n = 0, fd_n = 0, cyc = 0, first_acc = -1, first_win = -1, rdy0 = 0, sched = 0;
    bit pend = 0, v, acc_now;
    logic [9*DW-1:0] last_w = '0, e;
    for (int i = 0; i < N; i++) frame[i] = (mode == 0) ? DW'(i) : DW'($urandom);
    while (win_n < N && cyc < 6 * N + 200) begin
      @(negedge clk);
      checks++;
      if (win_valid !== pend) begin errors++; $display("FAIL win_valid mode=%0d cyc=%0d got=%b exp=%b", mode, cyc, win_valid, pend); end
      if (win_valid === 1'b1) begin
        e = exp_win(2 * W + 2 + win_n);
        checks++;
        if (win_out !== e) begin errors++; $display("FAIL win_out mode=%0d win=%0d got=%h exp=%h", mode, win_n, win_out, e); end
        checks++;
        if (frame_done !== (win_n == N - 1)) begin errors++; $display("FAIL frame_done mode=%0d win=%0d got=%b exp=%b", mode, win_n, frame_done, win_n == N - 1); end
        if (mode == 2 && win_n == N - 1) begin
          checks++;
          if (win_out[8*DW +: DW] !== '0) begin errors++; $display("FAIL flush_last_slice8 got=%h exp=00", win_out[8*DW +: DW]); end
        end
`ifdef MEDIAN_WINDOW_BORDER_EN
        checks++;
        if (win_border !== ((2*W+2+win_n) >= N || (2*W+2+win_n) % W < 2)) begin
          errors++; $display("FAIL win_border mode=%0d win=%0d got=%b", mode, win_n, win_border);
        end
`endif
        if (first_win < 0) first_win = cyc;
        last_w = win_out;
        win_n++;
      end else begin
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_idle mode=%0d cyc=%0d got=%b exp=0", mode, cyc, frame_done); end
        if (win_n > 0) begin
          checks++;
          if (win_out !== last_w) begin errors++; $display("FAIL win_hold mode=%0d cyc=%0d got=%h exp=%h", mode, cyc, win_out, last_w); end
        end
      end
      if (frame_done === 1'b1) fd_n++;
      if (acc_n == N && in_ready === 1'b0) rdy0++;
      if (acc_n < N) v = (mode == 1) ? (cyc % 2 == 0) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      else v = (mode == 2) && (in_ready === 1'b0);
      in_valid = v;
      pix_in = (acc_n < N) ? frame[acc_n] : 8'hFF;
      acc_now = v && in_ready === 1'b1;
      if (acc_n >= N) begin
        checks++;
        if (acc_now) begin errors++; $display("FAIL accept_in_flush mode=%0d cyc=%0d got=1 exp=0", mode, cyc); end
      end
      pend = (acc_now && acc_n >= 2 * W + 2 && acc_n < N) || (!acc_now && acc_n == N && sched < N);
      if (pend) sched++;
      if (acc_now && acc_n < N) begin
        if (acc_n == 0) first_acc = cyc;
        acc_n++;
      end
      cyc++;
    end
    in_valid = 0;
    checks++; if (win_n != N) begin errors++; $display("FAIL window_count mode=%0d got=%0d exp=%0d", mode, win_n, N); end
    checks++; if (fd_n != 1) begin errors++; $display("FAIL frame_done_count mode=%0d got=%0d exp=1", mode, fd_n); end
    checks++; if (rdy0 != 2 * W + 2) begin errors++; $display("FAIL flush_not_ready mode=%0d got=%0d exp=%0d", mode, rdy0, 2 * W + 2); end
    if (mode == 0 || mode == 3) begin
      checks++;
      if (first_win - first_acc != 2 * W + 3) begin errors++; $display("FAIL latency mode=%0d got=%0d exp=%0d", mode, first_win - first_acc, 2 * W + 3); end
    end
  endtask

  task automatic test_continuous();
    run_frame(0);
  endtask

  task automatic test_bubbles();
    run_frame(1);
  endtask

  task automatic test_flush_ignores_input();
    run_frame(2);
  endtask

  task automatic test_back_to_back();
    run_frame(3);
    run_frame(3);
  endtask

  task automatic test_reset_abort();
    int acc = 0, guard = 0;
    in_valid = 1;
    while (acc < 3 * W && guard < 10 * W) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL abort_frame_done_early got=%b exp=0", frame_done); end
      pix_in = 8'($urandom);
      if (in_ready === 1'b1) acc++;
      guard++;
    end
    reset = 1;
    in_valid = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || win_valid !== 1'b0) begin
        errors++; $display("FAIL abort_outputs frame_done=%b win_valid=%b exp=0/0", frame_done, win_valid);
      end
    end
    reset = 0;
    in_valid = 0;
    run_frame(3);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_bubbles();
    test_flush_ignores_input();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/median_window_3x3.md
Name: median_window_3x3

Overview:
- Streaming 3x3 neighbourhood generator that feeds the median sorter/control stage of the median filter datapath.
- Accepts one raster-order pixel per cycle and keeps two line buffers plus a 3x3 register window.
- Emits one 9-pixel window per accepted pixel once the window is full. At end of frame it self-flushes, so exactly IMG_W*IMG_H windows leave per frame.
- Latency is 2*IMG_W+3 cycles from the first pixel to the first window (515 for 256x256), which matches the downstream push start.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 256, pixels per line. Must be ≥ 4.
- IMG_H, 256, lines per frame.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  pix_in is valid this cycle.
- pix_in  input  DATA_W  raster-order pixel.
- in_ready  output  1  block accepts a pixel this cycle.
- win_valid  output  1  win_out holds a valid window this cycle.
- win_out  output  9*DATA_W  window; slice i = [i*DATA_W +: DATA_W], i = row*3+col.
  - Row 0 is the oldest line; col 0 is the oldest column.
  - Slice 8 is the newest pixel.
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Interface on reset:
  - Reset is synchronous and active-high on clk.
  - Reset values: in_ready=0, win_valid=0, win_out=0, frame_done=0.
  - State goes to FILL; in_cnt=0 and flush_cnt=0.
  - Line-buffer RAM contents are not cleared.
  - in_ready rises on the first cycle after reset deasserts.
- Accept rule:
  - A pixel is accepted when in_valid && in_ready.
  - No stall: a bubble (in_valid=0) freezes line buffers, window and counters, and win_valid=0 that cycle.
- Datapath on each accepted pixel (or flush step), the "shift event":
  - Line buffer LB1 (depth IMG_W) takes the incoming pixel.
  - LB2 (depth IMG_W) takes the LB1 output.
  - Window columns shift left: col 2 ← {LB2 out, LB1 out, incoming}, for rows 0, 1, 2.
- Counters:
  - in_cnt is 0..IMG_W*IMG_H-1, wide enough for IMG_W*IMG_H.
  - flush_cnt is 0..2*IMG_W+1.
- State FILL:
  - in_ready=1.
  - On acceptance of pixel index 2*IMG_W+1, go to STREAM.
  - No windows are emitted in FILL.
- State STREAM:
  - in_ready=1.
  - Each accepted pixel produces win_valid=1 on the next cycle (registered output, 1-cycle latency).
  - On acceptance of index IMG_W*IMG_H-1, go to FLUSH.
  - Windows straddling a line boundary are emitted unchanged; border treatment belongs to the consumer.
- State FLUSH:
  - in_ready=0; in_valid is ignored.
  - Runs exactly 2*IMG_W+2 consecutive cycles.
  - Each cycle injects a zero pixel as a shift event, and win_valid=1 on the following cycle.
  - On the final step, frame_done pulses together with that window's win_valid.
  - Then go to FILL with in_cnt=0.
- Window count per frame: (IMG_W*IMG_H - (2*IMG_W+2)) + (2*IMG_W+2) = IMG_W*IMG_H.
- Reset mid-frame:
  - Aborts immediately, with no frame_done.
  - The next frame starts from FILL; stale line-buffer data is fully overwritten before any window is emitted.
- in_valid asserted during reset or FLUSH: no effect.

Optional Feature:
- Macro: MEDIAN_WINDOW_BORDER_EN.
- Defined: adds output port win_border (1 bit), registered alongside win_valid, reset value 0.
- win_border=1 when the emitted window is not a true 3x3 neighbourhood, i.e. any of:
  - the newest pixel's column is 0 or 1 (line wrap);
  - the window contains any flush-injected zero.
- Not defined: port absent; no extra logic.

Test Plan:
- Reset, then IMG_W=256, IMG_H=256, pixels = index mod 256 with in_valid=1 continuously:
  - first win_valid appears exactly 515 cycles after the first accept;
  - win_out slice 8 = 2, slice 0 = 0, slice 4 = 1 (pattern row-major).
- Full continuous frame: count win_valid pulses = 65536; frame_done pulses once, same cycle as last window; in_ready=0 for exactly 514 cycles after the last pixel.
- Bubbles: in_valid toggled 1,0,1,0 in STREAM → win_valid follows each accept one cycle later; win_out holds through gaps; total window count unchanged.
- FLUSH ignores input: in_valid=1 with pix_in=8'hFF during FLUSH → no accept; the last window (slice 8) contains 0, not 8'hFF.
- Reset asserted at in_cnt=1000, then a fresh frame → no frame_done from the aborted frame; first window again at 515 cycles; its contents come only from the new frame.
- With MEDIAN_WINDOW_BORDER_EN, IMG_W=8, IMG_H=4:
  - window whose newest pixel is at column 1 → win_border=1;
  - newest at column 5, row 2 → win_border=0;
  - all 18 flush windows → win_border=1.
